// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M/RV64M multiply/divide unit.
// Build option MULDIV_FAST_SPECIAL_EN is consumed by muldiv_unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [63:0] MIN_SIGNED_SEED = 64'h8000_0000_0000_0000;

  // Most negative two's-complement value of an xlen-bit word, right-aligned.
  function automatic logic [63:0] min_signed(input int unsigned xlen);
    return MIN_SIGNED_SEED >> (32'd64 - xlen);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and for
// correcting the sign of unsigned iteration results.
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign data_o = neg_i ? (~data_i + ONE) : data_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_FAST_SPECIAL_EN to let trivial operations bypass CALC.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] data_o
);

  localparam logic [63:0]      MIN_WIDE = min_signed(XLEN);
  localparam logic [XLEN-1:0]  MIN_S    = MIN_WIDE[XLEN-1:0];
  localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     orig1_q, orig1_d;
  logic                neg_q, neg_d;
  logic                dz_q, dz_d;
  logic                ovf_q, ovf_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic                busy_q, done_q;

  logic                is_div_in_s, s1_s, s2_s, dz_in_s, ovf_in_s, neg_in_s, fast_in_s;
  logic [XLEN-1:0]     abs1_s, abs2_s, fast_res_s;
  logic [XLEN:0]       mul_sum_s, div_shift_s, div_diff_s;
  logic [2*XLEN-1:0]   mul_next_s, div_acc_next_s, prod_fix_s;
  logic                div_qbit_s;
  logic [XLEN-1:0]     div_rem_next_s, div_raw_s, div_res_s, result_s;

  // Accept-cycle decode: signedness, magnitudes and special cases.
  assign is_div_in_s = op_i[2];
  assign s1_s = (op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && data1_i[XLEN-1];
  assign s2_s = (op_i inside {OP_MULH, OP_DIV, OP_REM}) && data2_i[XLEN-1];
  assign neg_in_s = (op_i == OP_REM) ? s1_s : (s1_s ^ s2_s);
  assign dz_in_s  = is_div_in_s && (data2_i == ZERO);
  assign ovf_in_s = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                    (data1_i == MIN_S) && (data2_i == ONES);

  muldiv_sign_fix #(.W(XLEN)) u_abs1 (.data_i(data1_i), .neg_i(s1_s), .data_o(abs1_s));
  muldiv_sign_fix #(.W(XLEN)) u_abs2 (.data_i(data2_i), .neg_i(s2_s), .data_o(abs2_s));

`ifdef MULDIV_FAST_SPECIAL_EN
  assign fast_in_s = dz_in_s || ovf_in_s ||
                     (!is_div_in_s && ((data1_i == ZERO) || (data2_i == ZERO)));
`else
  assign fast_in_s = 1'b0;
`endif

  // Results that are known at acceptance and do not need the iteration.
  always_comb begin
    fast_res_s = ZERO;
    if (!is_div_in_s) begin
      fast_res_s = ZERO;
    end else if (dz_in_s) begin
      fast_res_s = op_i[1] ? data1_i : ONES;
    end else if (ovf_in_s) begin
      fast_res_s = op_i[1] ? ZERO : MIN_S;
    end else begin
      fast_res_s = ZERO;
    end
  end

  // One iteration step: multiplier bits sit in acc low half, dividend bits likewise.
  assign mul_sum_s      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {1'b0, ZERO});
  assign mul_next_s     = {mul_sum_s, acc_q[XLEN-1:1]};
  assign div_shift_s    = {rem_q, acc_q[XLEN-1]};
  assign div_diff_s     = div_shift_s - {1'b0, opnd_q};
  assign div_qbit_s     = ~div_diff_s[XLEN];
  assign div_rem_next_s = div_qbit_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
  assign div_acc_next_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_qbit_s};
  assign div_raw_s      = op_q[1] ? div_rem_next_s : div_acc_next_s[XLEN-1:0];

  muldiv_sign_fix #(.W(2*XLEN)) u_prod_fix (.data_i(mul_next_s), .neg_i(neg_q), .data_o(prod_fix_s));
  muldiv_sign_fix #(.W(XLEN))   u_div_fix  (.data_i(div_raw_s),  .neg_i(neg_q), .data_o(div_res_s));

  // Final-iteration result selection with special-case overrides.
  always_comb begin
    result_s = ZERO;
    if (!op_q[2]) begin
      result_s = (op_q == OP_MUL) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
    end else if (dz_q) begin
      result_s = op_q[1] ? orig1_q : ONES;
    end else if (ovf_q) begin
      result_s = op_q[1] ? ZERO : MIN_S;
    end else begin
      result_s = div_res_s;
    end
  end

  // Next-state and datapath update; flush wins over everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    orig1_d = orig1_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          op_d    = op_i;
          cnt_d   = {CNT_W{1'b0}};
          opnd_d  = is_div_in_s ? abs2_s : abs1_s;
          acc_d   = {ZERO, (is_div_in_s ? abs1_s : abs2_s)};
          rem_d   = ZERO;
          orig1_d = data1_i;
          neg_d   = neg_in_s;
          dz_d    = dz_in_s;
          ovf_d   = ovf_in_s;
          if (fast_in_s) begin
            state_d = ST_DONE;
            data_d  = fast_res_s;
          end else begin
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (op_q[2]) begin
            acc_d = div_acc_next_s;
            rem_d = div_rem_next_s;
          end else begin
            acc_d = mul_next_s;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            data_d  = result_s;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= 3'd0;
      opnd_q  <= ZERO;
      acc_q   <= {2{ZERO}};
      rem_q   <= ZERO;
      orig1_q <= ZERO;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      orig1_q <= orig1_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, latency and busy checks,
// flush/reset abort and held-start back-to-back behaviour.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;
`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = LAT;
`endif

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n_i, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] data1_i, data2_i;
  logic        busy_o, done_o;
  logic [31:0] data_o;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic [31:0] last_res = 32'd0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .flush_i(flush_i),
    .op_i(op_i), .data1_i(data1_i), .data2_i(data2_i),
    .busy_o(busy_o), .done_o(done_o), .data_o(data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done_o and checks value and timing.
  always @(posedge clk) begin
    #1;
    if (busy_o) busy_cnt = busy_cnt + 1;
    else busy_cnt = 0;
    if (done_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", data_o, e.res);
        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
      end
    end
  end

  // Call at a negedge where the unit is idle and start_i is being raised.
  task automatic push_exp(input logic [31:0] res, input int lat);
    sb_q.push_back('{res, cyc + 1, lat});
    last_res = res;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit special);
    wait_idle();
    op_i = op; data1_i = a; data2_i = b; start_i = 1'b1;
    push_exp(exp, special ? LAT_SPECIAL : LAT);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    rst_n_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = 3'd0; data1_i = 32'd0; data2_i = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    rst_n_i = 1'b1;

    // Multiply
    issue(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    issue(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
    issue(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    issue(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(OP_MULH,   32'hFFFF_FFFD,  32'd7,         32'hFFFF_FFFF, 1'b0);
    issue(OP_MULHU,  32'h0001_0000,  32'h0001_0000, 32'h0000_0001, 1'b0);
    issue(OP_MUL,    32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b0);
    issue(OP_MUL,    32'd0,          32'd5,         32'd0,         1'b1);
    issue(OP_MULH,   32'hFFFF_FFFF,  32'd0,         32'd0,         1'b1);
    // Divide
    issue(OP_DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, 1'b0);
    issue(OP_REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 1'b0);
    issue(OP_DIVU,   32'd20,         32'd6,         32'd3,         1'b0);
    issue(OP_REMU,   32'd20,         32'd6,         32'd2,         1'b0);
    issue(OP_DIV,    32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD, 1'b0);
    issue(OP_REM,    32'd20,         32'hFFFF_FFFA, 32'd2,         1'b0);
    issue(OP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0);
    issue(OP_REMU,   32'd100,        32'd7,         32'd2,         1'b0);
    // Special cases
    issue(OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1);
    issue(OP_REM,    32'd5,          32'd0,         32'd5,         1'b1);
    issue(OP_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1'b1);
    issue(OP_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b1);
    issue(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1);
    drain();

    // Flush has priority over start in IDLE
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; data1_i = 32'd9; data2_i = 32'd2;
    @(posedge clk); #1;
    check("flush_prio_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;

    // Flush in the middle of a divide
    prev = last_res;
    wait_idle();
    op_i = OP_DIV; data1_i = 32'd1000; data2_i = 32'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_done", {31'd0, done_o}, 32'd0);
    check("flush_data", data_o, prev);
    @(negedge clk);
    flush_i = 1'b0;
    repeat (40) @(negedge clk);
    check("flush_data_hold", data_o, prev);

    // Reset in the middle of a divide
    op_i = OP_DIV; data1_i = 32'd1000; data2_i = 32'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    rst_n_i = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_done", {31'd0, done_o}, 32'd0);
    check("arst_data", data_o, 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;
    last_res = 32'd0;
    repeat (40) @(negedge clk);
    check("arst_data_hold", data_o, 32'd0);

    // start_i held high: operand changes while busy are ignored
    wait_idle();
    op_i = OP_MUL; data1_i = 32'd3; data2_i = 32'd5; start_i = 1'b1;
    push_exp(32'd15, LAT);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy_o) break;
      op_i = OP_DIV; data1_i = 32'(k + 1000); data2_i = 32'd3;
    end
    check("b2b_idle", {31'd0, busy_o}, 32'd0);
    op_i = OP_DIVU; data1_i = 32'd100; data2_i = 32'd7;
    push_exp(32'd14, LAT);
    @(negedge clk);
    start_i = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative RV32M/RV64M multiply/divide unit that runs beside the single-cycle ALU in the EX stage.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over multiple cycles.
- Uses a start/busy/done handshake; the hazard unit stalls the pipeline while busy_o is high.
- Replaces the need to widen the single-cycle ALU with a multiplier array.

Parameters:
- XLEN, 32, operand and result width in bits. Legal values: 32 or 64.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter. Derived; must not be overridden.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  request to begin an operation. Accepted only when busy_o=0.
- flush_i  input  1  aborts any operation in flight; the unit returns to IDLE next cycle.
- op_i  input  3  operation, equal to funct3 of the M-extension encoding:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- data1_i  input  XLEN  rs1 operand. Sampled only on the accepting cycle.
- data2_i  input  XLEN  rs2 operand. Sampled only on the accepting cycle.
- busy_o  output  1  high in CALC and DONE.
- done_o  output  1  one-cycle pulse; data_o is valid in this cycle.
- data_o  output  XLEN  result register. Holds its value until the next DONE.

Behaviour:
- Reset: state=IDLE, busy_o=0, done_o=0, data_o=0. The counter and internal registers are cleared. Reset asserted mid-operation aborts immediately; there is no result and no done_o.
- State machine has three states: IDLE, CALC, DONE.
  - IDLE -> CALC on start_i && !flush_i.
  - CALC -> DONE when the counter reaches XLEN-1 on its final iteration.
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE on flush_i. flush_i has priority over start_i in the same cycle.
- Accept cycle (IDLE, start_i=1):
  - Latch op_i.
  - Latch the absolute values of the operands according to signedness:
    - MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - DIV/REM: both operands signed.
    - All other ops: unsigned.
  - Record the result sign. Product sign = s1^s2. Quotient sign = s1^s2. Remainder sign = s1.
- start_i is ignored while busy_o=1; it is not queued.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2*XLEN accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, using an XLEN+1-bit partial remainder.
- CALC lasts exactly XLEN cycles. Latency from the accepting edge to done_o is XLEN+1 cycles, i.e. done_o asserts in cycle XLEN+1.
- Result on entry to DONE:
  - Apply the sign fix (two's complement) at 2*XLEN width for multiply and XLEN width for divide.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - data_o is written once, on entry to DONE.
- Divide by zero: quotient = all ones; remainder = data1_i unchanged, for signed and unsigned ops.
- Signed overflow (data1_i = -2^(XLEN-1), data2_i = -1, DIV/REM): quotient = data1_i, remainder = 0.
- These special results are fixed regardless of iteration; the datapath overrides them at the DONE write.
- done_o is high only in DONE. A back-to-back start_i is accepted in the first IDLE cycle after DONE.

Optional Feature:
- Macro: MULDIV_FAST_SPECIAL_EN.
- Defined: the following cases skip CALC and go IDLE -> DONE directly, giving done_o in cycle 1 after acceptance:
  - divide by zero
  - signed overflow
  - multiply with either operand zero
  - Results are identical to the non-fast path; busy_o stays high for exactly one cycle (DONE).
- Not defined: every operation takes the full XLEN+1 latency. The bench must check the latency for both builds.

Decomposition:
- Shared package muldiv_pkg holds:
  - the 3-bit op encodings, MUL through REMU
  - the state encoding (IDLE/CALC/DONE)
  - a helper constant for XLEN-dependent minimum-signed value generation
- One sub-module is natural: muldiv_sign_fix, a combinational conditional two's complement negate, parameterised by width. It is instantiated for operand abs-value and for result correction.
- The FSM, counter and shift datapath stay in muldiv_unit.

Test Plan:
- MUL: 7 x -3 (0xFFFFFFFD), XLEN=32 -> data_o = 0xFFFFFFEB, done_o in cycle 33, busy_o high cycles 1-33.
- MULH: 0x80000000 x 0x80000000 -> data_o = 0x40000000. MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> data_o = 0xFFFFFFFE. MULHSU: -1 x 0xFFFFFFFF -> data_o = 0xFFFFFFFF.
- DIV: -20 / 6 -> data_o = -3 (0xFFFFFFFD). REM: -20 % 6 -> data_o = -2 (0xFFFFFFFE). DIVU: 20 / 6 -> data_o = 3.
- Special cases:
  - DIVU 5 / 0 -> data_o = 0xFFFFFFFF.
  - REM 5 % 0 -> data_o = 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> data_o = 0x80000000.
  - REM of the same operands -> data_o = 0.
  - With MULDIV_FAST_SPECIAL_EN, done_o in cycle 1.
- Flush and reset abort:
  - start DIV, assert flush_i in cycle 10 -> IDLE next cycle, no done_o, data_o keeps its previous value.
  - Repeat with rst_n_i low in cycle 10 -> all outputs 0.
- Ignored start and back-to-back: start_i held high continuously with changing operands -> only the first operand set is used; the next operation is accepted the cycle after done_o; two results in sequence are both correct.
